reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Shares the register-file write port between N_REQ requesters, e.g. control-unit writeback and a debug/load port.
//  Selects one requester per cycle, round-robin, and decodes its 4-bit register index into a one-hot R0in..R15in strobe.
//  Drives that requester's data onto the write bus and returns a one-cycle grant.
//  Sits between the requesters and the register-file Rin enables; supports locked multi-cycle ownership.
// PARAMETERS
//  N_REQ     2   number of requesters (2..8)
//  DATA_W    32  write-data width
//  MAX_LOCK  8   max consecutive locked grants before forced release (>=1)
// PORTS
//  clock     in   1              rising-edge clock
//  reset     in   1              synchronous, active-high reset
//  req       in   N_REQ          write request per requester
//  lock      in   N_REQ          keep ownership after this grant
//  reg_idx   in   N_REQ*4        flat per-requester register index, [4i+3:4i]
//  wdata     in   N_REQ*DATA_W   flat per-requester write data
//  gnt       out  N_REQ          one-hot grant pulse, registered
//  reg_in    out  16             one-hot register write enable, registered
//  bus_out   out  DATA_W         write data for granted requester, registered
//  wr_valid  out  1              reg_in/bus_out valid this cycle
//  lock_err  out  1              1-cycle pulse on forced lock release
//  r0_block  out  1              1-cycle pulse on suppressed R0 write (R0_PROTECT_EN only)
// BEHAVIOUR
//  - Reset: one clock with reset=1 sets all outputs to 0, rr pointer to 0, state IDLE, lock counter to 0.
//    Reset overrides any in-flight grant or lock.
//  - Sampling: req/reg_idx/wdata are sampled at the clock edge; the winner's outputs appear the following cycle (latency 1).
//  - Outputs in the cycle after a win:
//      gnt[w]=1; reg_in=1<<reg_idx[w]; bus_out=wdata[w]; wr_valid=1.
//    With no winner: gnt, reg_in and bus_out are 0 and wr_valid=0.
//  - Handshake:
//      requester holds req, reg_idx and wdata stable until it sees gnt.
//      If req is still high at the edge ending the gnt cycle, that is a new request; back-to-back writes give 1 write/cycle.
//  - Arbitration: round-robin starting at ptr.
//      After each grant, ptr = (w+1) mod N_REQ.
//      Requests not granted stay pending with no loss.
//  - States:
//      IDLE: no owner. A win with lock[w]=0 stays in IDLE; a win with lock[w]=1 goes to LOCKED(owner=w), cnt=1.
//      LOCKED: only the owner may be granted; other requests wait.
//        owner req=1 & lock=1 & cnt<MAX_LOCK -> grant, cnt++.
//        owner req=1 & lock=0 -> grant, go to IDLE.
//        owner req=0 -> no grant, go to IDLE; the other requesters are arbitrated from the next edge.
//        cnt==MAX_LOCK & owner still locking -> no grant, lock_err pulse, go to IDLE, ptr=owner+1.
//  - reg_in is always one-hot or zero, never multi-hot.
//  - With wr_valid=1, reg_in decodes 0..15 exactly; index 15 sets reg_in[15].
//  - N_REQ=1: always grants req[0] on the next cycle; the pointer is unused.
// CONFIGURATION
//  - R0_PROTECT_EN defined:
//      a granted write with reg_idx=0 still pulses gnt (requester is released).
//      In that cycle reg_in=0, wr_valid=0 and r0_block=1.
//  - R0_PROTECT_EN undefined:
//      R0 is written like any other register.
//      r0_block is tied to 0.
// STRUCTURE
//  - Package reg_sel_pkg: NUM_REGS=16, REG_IDX_W=4, state enum {IDLE, LOCKED}.
//  - Sub-module rr_arbiter: params N; inputs req, ptr, mask; outputs one-hot win and win_idx; combinational.
//  - The top module holds the FSM, ptr, lock counter, index decode and output registers.
// TESTING
//  1. Reset mid-LOCKED: reset=1 for one cycle -> next cycle all outputs 0; req[1] on the following edge wins (ptr=0, only req).
//  2. N_REQ=2, req=2'b11 held for 4 cycles, idx0=3, idx1=9 ->
//     gnt alternates 01,10,01,10; reg_in alternates 0x0008,0x0200.
//  3. req[0] with lock=1 for 3 cycles, then lock=0, with req[1] high throughout ->
//     4 consecutive gnt[0], then gnt[1].
//  4. MAX_LOCK=8, requester 0 locks indefinitely ->
//     8 grants, 1 idle cycle with lock_err=1, then gnt[1].
//  5. reg_idx=15, wdata=0xDEADBEEF -> reg_in=0x8000, bus_out=0xDEADBEEF, wr_valid=1 one cycle later.
//  6. reg_idx=0 with R0_PROTECT_EN -> gnt=1, reg_in=0, r0_block=1.
//     Without the macro -> reg_in=0x0001.

Source files
------------

// File: rtl/reg_sel_pkg.sv
// Shared definitions for the register-file write arbiter: register count,
// index width, arbiter FSM states and the index-to-strobe decoder.
package reg_sel_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REGS-1:0] idx_decode(input logic [REG_IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] one_hot;
    one_hot      = '0;
    one_hot[idx] = 1'b1;
    return one_hot;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr whose
// request is set and not masked off. Outputs one-hot win and its index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx
);

  logic found_s;
  int   slot_s;

  // Scan N slots starting at ptr with wrap-around; keep the first eligible one.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found_s = 1'b0;
    slot_s  = 0;
    for (int k = 0; k < N; k++) begin
      slot_s = int'(ptr) + k;
      if (slot_s >= N) begin
        slot_s = slot_s - N;
      end else begin
        slot_s = slot_s;
      end
      if (!found_s && req[slot_s] && mask[slot_s]) begin
        found_s      = 1'b1;
        win[slot_s]  = 1'b1;
        win_idx      = IW'(slot_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin register-file write-port arbiter with locked ownership and a
// one-hot Rin strobe decoder. Optional R0 write suppression: R0_PROTECT_EN.
module reg_write_arbiter
  import reg_sel_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            lock,
  input  logic [N_REQ*REG_IDX_W-1:0]  reg_idx,
  input  logic [N_REQ*DATA_W-1:0]     wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [NUM_REGS-1:0]         reg_in,
  output logic [DATA_W-1:0]           bus_out,
  output logic                        wr_valid,
  output logic                        lock_err,
  output logic                        r0_block
);

  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LOCK);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REGS-1:0]  reg_in_q, reg_in_d;
  logic [DATA_W-1:0]    bus_q, bus_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 lock_err_q, lock_err_d;

  logic [N_REQ-1:0]     mask_s;
  logic [N_REQ-1:0]     win_s;
  logic [IW-1:0]        win_idx_s;
  logic [IW-1:0]        ptr_next_s;
  logic                 grant_s;
  logic [REG_IDX_W-1:0] sel_idx_s;
  logic [DATA_W-1:0]    sel_data_s;
  logic [REG_IDX_W-1:0] idx_arr_s  [N_REQ];
  logic [DATA_W-1:0]    data_arr_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign idx_arr_s[g]  = reg_idx[g*REG_IDX_W +: REG_IDX_W];
    assign data_arr_s[g] = wdata[g*DATA_W +: DATA_W];
  end

  // While locked only the owner is eligible; otherwise everyone competes.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask_s[i] = (state_q == IDLE) || (owner_q == IW'(i));
    end
  end

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .mask    (mask_s),
    .win     (win_s),
    .win_idx (win_idx_s)
  );

  assign ptr_next_s = (win_idx_s == LAST_IDX) ? '0 : (win_idx_s + IW'(1));
  assign sel_idx_s  = idx_arr_s[win_idx_s];
  assign sel_data_s = data_arr_s[win_idx_s];

  // Ownership FSM: decides whether the picked requester is granted this edge.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    grant_s    = 1'b0;
    lock_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|win_s) begin
          grant_s = 1'b1;
          ptr_d   = ptr_next_s;
          if (lock[win_idx_s]) begin
            state_d = LOCKED;
            owner_d = win_idx_s;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!lock[owner_q]) begin
          grant_s = 1'b1;
          ptr_d   = ptr_next_s;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q < MAX_CNT) begin
          grant_s = 1'b1;
          ptr_d   = ptr_next_s;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          // Owner exhausted its budget: withhold the grant and hand priority on.
          lock_err_d = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
          ptr_d      = ptr_next_s;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef R0_PROTECT_EN
  logic r0_block_q, r0_block_d;
`endif

  // Next-cycle write-port outputs for the granted requester.
  always_comb begin
    gnt_d      = '0;
    reg_in_d   = '0;
    bus_d      = '0;
    wr_valid_d = 1'b0;
`ifdef R0_PROTECT_EN
    r0_block_d = 1'b0;
`endif
    if (grant_s) begin
      gnt_d = win_s;
`ifdef R0_PROTECT_EN
      if (sel_idx_s == REG_IDX_W'(0)) begin
        r0_block_d = 1'b1;
      end else begin
        reg_in_d   = idx_decode(sel_idx_s);
        bus_d      = sel_data_s;
        wr_valid_d = 1'b1;
      end
`else
      reg_in_d   = idx_decode(sel_idx_s);
      bus_d      = sel_data_s;
      wr_valid_d = 1'b1;
`endif
    end else begin
      gnt_d = '0;
    end
  end

  // State, pointer, lock counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      reg_in_q   <= '0;
      bus_q      <= '0;
      wr_valid_q <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      reg_in_q   <= reg_in_d;
      bus_q      <= bus_d;
      wr_valid_q <= wr_valid_d;
      lock_err_q <= lock_err_d;
    end
  end

`ifdef R0_PROTECT_EN
  // Suppressed-R0-write indicator register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r0_block_q <= 1'b0;
    end else begin
      r0_block_q <= r0_block_d;
    end
  end
  assign r0_block = r0_block_q;
`else
  assign r0_block = 1'b0;
`endif

  assign gnt      = gnt_q;
  assign reg_in   = reg_in_q;
  assign bus_out  = bus_q;
  assign wr_valid = wr_valid_q;
  assign lock_err = lock_err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter (N_REQ=2, MAX_LOCK=8): directed
// scenarios followed by randomized traffic that obeys the request handshake.
module tb_reg_write_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int ML = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [1:0]    lock;
  logic [7:0]    reg_idx;
  logic [63:0]   wdata;
  logic [1:0]    gnt;
  logic [15:0]   reg_in;
  logic [31:0]   bus_out;
  logic          wr_valid;
  logic          lock_err;
  logic          r0_block;

  reg_write_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .lock     (lock),
    .reg_idx  (reg_idx),
    .wdata    (wdata),
    .gnt      (gnt),
    .reg_in   (reg_in),
    .bus_out  (bus_out),
    .wr_valid (wr_valid),
    .lock_err (lock_err),
    .r0_block (r0_block)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  gnt;
    logic [15:0] reg_in;
    logic [31:0] bus;
    logic        valid;
    logic        lerr;
    logic        r0b;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: plain integers describing ownership and fairness.
  int m_ptr    = 0;
  int m_owner  = 0;
  int m_cnt    = 0;
  bit m_locked = 1'b0;
  int m_win    = -1;

  task automatic model_step(input bit rst, input logic [1:0] r, input logic [1:0] l,
                            input logic [3:0] i0, input logic [3:0] i1,
                            input logic [31:0] d0, input logic [31:0] d1);
    exp_t        e;
    logic [3:0]  idx;
    logic [31:0] dat;
    e.gnt = 2'b00; e.reg_in = 16'h0000; e.bus = 32'h0; e.valid = 1'b0; e.lerr = 1'b0; e.r0b = 1'b0;
    m_win = -1;
    if (rst) begin
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
    end else begin
      if (m_locked) begin
        if (!r[m_owner]) m_locked = 1'b0;
        else if (!l[m_owner]) begin m_win = m_owner; m_locked = 1'b0; end
        else if (m_cnt < ML) begin m_win = m_owner; m_cnt++; end
        else begin e.lerr = 1'b1; m_locked = 1'b0; m_ptr = (m_owner + 1) % N; end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (m_win < 0 && r[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        end
        if (m_win >= 0 && l[m_win]) begin m_locked = 1'b1; m_owner = m_win; m_cnt = 1; end
      end
      if (m_win >= 0) begin
        m_ptr = (m_win + 1) % N;
        e.gnt[m_win] = 1'b1;
        idx = (m_win == 0) ? i0 : i1;
        dat = (m_win == 0) ? d0 : d1;
`ifdef R0_PROTECT_EN
        if (idx == 4'd0) e.r0b = 1'b1;
        else begin e.reg_in[idx] = 1'b1; e.bus = dat; e.valid = 1'b1; end
`else
        e.reg_in[idx] = 1'b1; e.bus = dat; e.valid = 1'b1;
`endif
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input logic [1:0] r, input logic [1:0] l,
                       input logic [3:0] i0, input logic [3:0] i1,
                       input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clock);
    reset   = rst;
    req     = r;
    lock    = l;
    reg_idx = {i1, i0};
    wdata   = {d1, d0};
    model_step(rst, r, l, i0, i1, d0, d1);
  endtask

  // Monitor: one registered output set per cycle, checked against the queue.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (gnt !== e.gnt || reg_in !== e.reg_in || bus_out !== e.bus ||
            wr_valid !== e.valid || lock_err !== e.lerr || r0_block !== e.r0b) begin
          miscompares++;
          $display("FAIL vec%0d @%0t: got gnt=%b reg_in=%h bus=%h wv=%b lerr=%b r0b=%b, want gnt=%b reg_in=%h bus=%h wv=%b lerr=%b r0b=%b",
                   vectors, $time, gnt, reg_in, bus_out, wr_valid, lock_err, r0_block,
                   e.gnt, e.reg_in, e.bus, e.valid, e.lerr, e.r0b);
        end
      end
    end
  end

  bit [1:0]    cur_r;
  logic [3:0]  ci [2];
  logic [31:0] cd [2];
  logic [1:0]  rl;
  bit          rr;

  initial begin
    reset = 1'b1; req = 2'b00; lock = 2'b00; reg_idx = 8'h00; wdata = 64'h0;
    drive(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    drive(0, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);

    // Reset while requester 0 holds a lock, then requester 1 alone wins.
    repeat (3) drive(0, 2'b01, 2'b01, 4'd5, 4'd6, 32'h1111_0000, 32'h2222_0000);
    drive(1, 2'b01, 2'b01, 4'd5, 4'd6, 32'h1111_0000, 32'h2222_0000);
    drive(0, 2'b10, 2'b00, 4'd5, 4'd6, 32'h1111_0000, 32'h2222_0000);
    drive(0, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);

    // Two continuous requesters alternate.
    repeat (4) drive(0, 2'b11, 2'b00, 4'd3, 4'd9, 32'hA0A0_0003, 32'hB0B0_0009);
    drive(0, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);

    // Three locked grants, one unlocking grant, then the waiting requester.
    repeat (3) drive(0, 2'b11, 2'b01, 4'd1, 4'd2, 32'hC0DE_0001, 32'hC0DE_0002);
    drive(0, 2'b11, 2'b00, 4'd1, 4'd2, 32'hC0DE_0001, 32'hC0DE_0002);
    drive(0, 2'b10, 2'b00, 4'd1, 4'd2, 32'hC0DE_0001, 32'hC0DE_0002);
    drive(0, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);

    // Endless lock: MAX_LOCK grants, a lock_err cycle, then requester 1.
    repeat (10) drive(0, 2'b11, 2'b01, 4'd4, 4'd7, 32'h0000_0044, 32'h0000_0077);
    drive(0, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);

    // Highest index and register 0.
    drive(0, 2'b01, 2'b00, 4'd15, 4'd0, 32'hDEAD_BEEF, 32'h0);
    drive(0, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    drive(0, 2'b01, 2'b00, 4'd0, 4'd0, 32'h1234_5678, 32'h0);
    drive(0, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);

    // Random traffic: requesters hold their request until the model grants it.
    cur_r = 2'b00;
    for (int i = 0; i < 2; i++) begin ci[i] = 4'd0; cd[i] = 32'h0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!cur_r[i] && $urandom_range(99) < 60) begin
          cur_r[i] = 1'b1;
          ci[i]    = 4'($urandom);
          cd[i]    = $urandom;
        end
      end
      for (int i = 0; i < 2; i++) begin
        rl[i] = ($urandom_range(99) < ((cyc < 1500) ? 30 : 90));
      end
      rr = ($urandom_range(299) == 0);
      drive(rr, cur_r, rl, ci[0], ci[1], cd[0], cd[1]);
      if (m_win >= 0) begin
        if ($urandom_range(1) == 0) cur_r[m_win] = 1'b0;
        else begin ci[m_win] = 4'($urandom); cd[m_win] = $urandom; end
      end
    end
    drive(0, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
